// File: rtl/pong_score_keeper.sv
// Pong scoring controller: edge-detects point inputs, keeps two 4-bit scores,
// and sequences IDLE -> PLAY -> PAUSE / GAME_OVER with a winner flag.
module pong_score_keeper #(
    parameter int WIN_SCORE    = 9,
    parameter int PAUSE_CYCLES = 25000000
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_START,
    input  logic       i_P1_POINT,
    input  logic       i_P2_POINT,
    output logic [3:0] o_P1_SCORE,
    output logic [3:0] o_P2_SCORE,
    output logic       o_GAME_ACTIVE,
    output logic       o_PAUSE,
    output logic [1:0] o_WINNER
);

    localparam int CNT_W = $clog2(PAUSE_CYCLES + 1);
    localparam logic [CNT_W-1:0] PAUSE_LOAD = CNT_W'(PAUSE_CYCLES - 1);
    localparam logic [3:0]       WIN_VAL    = 4'(WIN_SCORE);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_PLAY      = 2'd1;
    localparam logic [1:0] S_PAUSE     = 2'd2;
    localparam logic [1:0] S_GAME_OVER = 2'd3;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [3:0]       p1_score_q, p1_score_d;
    logic [3:0]       p2_score_q, p2_score_d;
    logic [1:0]       winner_q, winner_d;
    logic [CNT_W-1:0] pause_cnt_q, pause_cnt_d;
    logic             p1_prev_q, p2_prev_q;
    logic             game_active_q, pause_q;

    logic       p1_event, p2_event;
    logic [3:0] p1_next, p2_next;

    assign p1_event = i_P1_POINT & ~p1_prev_q;
    assign p2_event = i_P2_POINT & ~p2_prev_q;
    assign p1_next  = p1_score_q + 4'd1;
    assign p2_next  = p2_score_q + 4'd1;

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latch).
        state_d     = state_q;
        p1_score_d  = p1_score_q;
        p2_score_d  = p2_score_q;
        winner_d    = winner_q;
        pause_cnt_d = pause_cnt_q;

        case (state_q)
            S_IDLE: begin
                p1_score_d = 4'd0;
                p2_score_d = 4'd0;
                winner_d   = WIN_NONE;
                if (i_START) state_d = S_PLAY;
            end
            S_PLAY: begin
                // Simultaneous events cancel: only exactly one event scores.
                if (p1_event && !p2_event) begin
                    p1_score_d = p1_next;
                    if (p1_next == WIN_VAL) begin
                        state_d  = S_GAME_OVER;
                        winner_d = WIN_P1;
                    end else begin
                        state_d     = S_PAUSE;
                        pause_cnt_d = PAUSE_LOAD;
                    end
                end else if (p2_event && !p1_event) begin
                    p2_score_d = p2_next;
                    if (p2_next == WIN_VAL) begin
                        state_d  = S_GAME_OVER;
                        winner_d = WIN_P2;
                    end else begin
                        state_d     = S_PAUSE;
                        pause_cnt_d = PAUSE_LOAD;
                    end
                end
            end
            S_PAUSE: begin
                if (pause_cnt_q == '0) state_d = S_PLAY;
                else                   pause_cnt_d = pause_cnt_q - 1'b1;
            end
            S_GAME_OVER: begin
                if (i_START) begin
                    p1_score_d = 4'd0;
                    p2_score_d = 4'd0;
                    winner_d   = WIN_NONE;
                    state_d    = S_PLAY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample the same edge.
        if (i_RST) begin
            state_q       <= S_IDLE;
            p1_score_q    <= 4'd0;
            p2_score_q    <= 4'd0;
            winner_q      <= WIN_NONE;
            pause_cnt_q   <= '0;
            p1_prev_q     <= 1'b0;
            p2_prev_q     <= 1'b0;
            game_active_q <= 1'b0;
            pause_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            p1_score_q    <= p1_score_d;
            p2_score_q    <= p2_score_d;
            winner_q      <= winner_d;
            pause_cnt_q   <= pause_cnt_d;
            p1_prev_q     <= i_P1_POINT;
            p2_prev_q     <= i_P2_POINT;
            game_active_q <= (state_d == S_PLAY);
            pause_q       <= (state_d == S_PAUSE);
        end
    end

    assign o_P1_SCORE    = p1_score_q;
    assign o_P2_SCORE    = p2_score_q;
    assign o_GAME_ACTIVE = game_active_q;
    assign o_PAUSE       = pause_q;
    assign o_WINNER      = winner_q;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Bench for pong_score_keeper: two instances (win at 3 and at 15) share stimulus
// and are compared every cycle against a behavioural game model.
module tb_pong_score_keeper;

    localparam int PAUSE_N = 4;
    localparam int WIN_A   = 3;
    localparam int WIN_B   = 15;

    logic clk = 1'b0;
    logic rst, start, p1, p2;

    logic [3:0] a_s1, a_s2, b_s1, b_s2;
    logic       a_act, a_pause, b_act, b_pause;
    logic [1:0] a_win, b_win;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pong_score_keeper #(.WIN_SCORE(WIN_A), .PAUSE_CYCLES(PAUSE_N)) dut_a (
        .i_CLK(clk), .i_RST(rst), .i_START(start),
        .i_P1_POINT(p1), .i_P2_POINT(p2),
        .o_P1_SCORE(a_s1), .o_P2_SCORE(a_s2),
        .o_GAME_ACTIVE(a_act), .o_PAUSE(a_pause), .o_WINNER(a_win)
    );

    pong_score_keeper #(.WIN_SCORE(WIN_B), .PAUSE_CYCLES(PAUSE_N)) dut_b (
        .i_CLK(clk), .i_RST(rst), .i_START(start),
        .i_P1_POINT(p1), .i_P2_POINT(p2),
        .o_P1_SCORE(b_s1), .o_P2_SCORE(b_s2),
        .o_GAME_ACTIVE(b_act), .o_PAUSE(b_pause), .o_WINNER(b_win)
    );

    // Behavioural model: game phase, scores, winner and pause cycles still to run.
    typedef enum {M_IDLE, M_PLAY, M_PAUSE, M_OVER} mode_e;
    mode_e m_mode [2];
    int    m_s1   [2];
    int    m_s2   [2];
    int    m_win  [2];
    int    m_left [2];
    bit    m_prev1, m_prev2;
    int    win_of [2] = '{WIN_A, WIN_B};

    task automatic model_edge();
        bit ev1, ev2;
        ev1 = p1 && !m_prev1;
        ev2 = p2 && !m_prev2;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_mode[k] = M_IDLE; m_s1[k] = 0; m_s2[k] = 0; m_win[k] = 0; m_left[k] = 0;
            end else begin
                case (m_mode[k])
                    M_IDLE: if (start) m_mode[k] = M_PLAY;
                    M_PLAY: if (ev1 != ev2) begin
                        if (ev1) m_s1[k]++; else m_s2[k]++;
                        if ((ev1 ? m_s1[k] : m_s2[k]) == win_of[k]) begin
                            m_mode[k] = M_OVER;
                            m_win[k]  = ev1 ? 1 : 2;
                        end else begin
                            m_mode[k] = M_PAUSE;
                            m_left[k] = PAUSE_N;
                        end
                    end
                    M_PAUSE: begin
                        m_left[k]--;
                        if (m_left[k] == 0) m_mode[k] = M_PLAY;
                    end
                    M_OVER: if (start) begin
                        m_s1[k] = 0; m_s2[k] = 0; m_win[k] = 0; m_mode[k] = M_PLAY;
                    end
                endcase
            end
        end
        if (rst) begin
            m_prev1 = 1'b0; m_prev2 = 1'b0;
        end else begin
            m_prev1 = p1; m_prev2 = p2;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("a_p1_score", a_s1, 4'(m_s1[0]));
        check("a_p2_score", a_s2, 4'(m_s2[0]));
        check("a_active",   {3'b0, a_act},   {3'b0, m_mode[0] == M_PLAY});
        check("a_pause",    {3'b0, a_pause}, {3'b0, m_mode[0] == M_PAUSE});
        check("a_winner",   {2'b0, a_win},   4'(m_win[0]));
        check("b_p1_score", b_s1, 4'(m_s1[1]));
        check("b_p2_score", b_s2, 4'(m_s2[1]));
        check("b_active",   {3'b0, b_act},   {3'b0, m_mode[1] == M_PLAY});
        check("b_pause",    {3'b0, b_pause}, {3'b0, m_mode[1] == M_PAUSE});
        check("b_winner",   {2'b0, b_win},   4'(m_win[1]));
    endtask

    // Apply inputs for one edge, advance the model, then compare just after the edge.
    task automatic tick(input bit r, input bit s, input bit a, input bit b);
        rst = r; start = s; p1 = a; p2 = b;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
    endtask

    task automatic point(input bit who_p1);
        tick(0, 0, who_p1, !who_p1);
        idle(PAUSE_N + 2);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; p1 = 1'b0; p2 = 1'b0;
        m_prev1 = 1'b0; m_prev2 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = M_IDLE; m_s1[k] = 0; m_s2[k] = 0; m_win[k] = 0; m_left[k] = 0;
        end

        // Reset then start
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        check("reset_active", {3'b0, a_act}, 4'd0);
        check("reset_winner", {2'b0, a_win}, 4'd0);
        tick(0, 1, 1, 0);
        check("start_active", {3'b0, a_act}, 4'd1);
        check("start_ignores_point", a_s1, 4'd0);
        idle(2);

        // Single long point: one score, exactly PAUSE_N cycles of pause
        tick(0, 0, 1, 0);
        check("long_first_pause", {3'b0, a_pause}, 4'd1);
        for (int i = 0; i < 9; i++) tick(0, 0, 1, 0);
        check("long_point_once", a_s1, 4'd1);
        idle(2);

        // Simultaneous events cancel
        tick(0, 0, 1, 1);
        check("simul_active", {3'b0, a_act}, 4'd1);
        check("simul_p2", a_s2, 4'd0);
        idle(2);

        // Game to win from a fresh start
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);
        point(0); point(0); point(1); point(0);
        check("win_p2_score", a_s2, 4'd3);
        check("win_p1_score", a_s1, 4'd1);
        check("win_winner", {2'b0, a_win}, 4'd2);
        point(1);
        check("over_frozen_p1", a_s1, 4'd1);
        tick(0, 1, 0, 0);
        check("restart_winner", {2'b0, a_win}, 4'd0);
        check("restart_p2", a_s2, 4'd0);
        idle(1);

        // Pause masking and ignored start during pause
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        tick(0, 1, 1, 0);
        idle(PAUSE_N);
        check("pause_mask_p1", a_s1, 4'd0);

        // Reset in PAUSE with scores 2/1
        point(1);
        tick(0, 0, 1, 0);
        check("pre_reset_p1", a_s1, 4'd2);
        tick(1, 1, 1, 1);
        check("mid_reset_p1", a_s1, 4'd0);
        check("mid_reset_pause", {3'b0, a_pause}, 4'd0);
        check("mid_reset_active", {3'b0, a_act}, 4'd0);
        idle(2);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit r, s, a, b;
            r = ($urandom_range(499) == 0);
            s = ($urandom_range(19) == 0);
            a = ($urandom_range(7) == 0) ? !p1 : p1;
            b = ($urandom_range(7) == 0) ? !p2 : p2;
            tick(r, s, a, b);
        end

        // Scores reach 15 without wrapping on the WIN_SCORE=15 instance
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);
        for (int i = 0; i < 15; i++) point(1);
        check("b_reach_15", b_s1, 4'd15);
        check("b_winner_p1", {2'b0, b_win}, 4'd1);
        point(1);
        check("b_no_wrap", b_s1, 4'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
